dsi_hs_rx_monitor: RTL and testbench

DSI_HS_RX_MONITOR -- requirements
Module: dsi_hs_rx_monitor

---
 rtl/dsi_hs_rx_monitor.sv | 188 ++++++++++++++++++
 tb/tb_dsi_hs_rx_monitor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsi_hs_rx_monitor.sv
// DSI HS lane monitor: parses the first packet of every HS burst and keeps wrap-around statistics.
// Optional header ECC checking is built in when DSI_HS_RX_MONITOR_ECC_CHECK_EN is defined.
module dsi_hs_rx_monitor #(
   parameter int NUM_LANES = 4,
   parameter int CNT_W     = 16
) (
   input  logic             i_mipi_tx_pclk,
   input  logic             i_rst,
   input  logic [3:0]       i_hs_oe,
   input  logic [7:0]       i_hs_d0,
   input  logic [7:0]       i_hs_d1,
   input  logic [7:0]       i_hs_d2,
   input  logic [7:0]       i_hs_d3,
   output logic             o_pkt_valid,
   output logic [1:0]       o_pkt_vc,
   output logic [5:0]       o_pkt_dt,
   output logic [15:0]      o_pkt_wc,
   output logic             o_long_done,
   output logic [CNT_W-1:0] o_burst_cnt,
   output logic [CNT_W-1:0] o_frame_cnt,
   output logic [CNT_W-1:0] o_line_cnt,
   output logic [CNT_W-1:0] o_long_cnt,
   output logic [CNT_W-1:0] o_sync_err_cnt,
   output logic [CNT_W-1:0] o_trunc_err_cnt,
   output logic [CNT_W-1:0] o_ecc_err_cnt
);

   localparam logic [7:0]       SYNC_BYTE = 8'hB8;
   localparam logic [1:0]       HDR_LAST  = 2'(4 / NUM_LANES - 1);
   localparam logic [16:0]      LANE_STEP = 17'(NUM_LANES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DRAIN} state_t;

   state_t      state;
   logic        prev_oe;
   logic        start_blk;
   logic [1:0]  hdr_cyc;
   logic [7:0]  hdr_q [4];
   logic [16:0] rem_cnt;
   logic [7:0]  lane_d [4];
   logic [7:0]  hdr_w [4];
   logic        oe0;
   logic        burst_start;
   logic        sync_ok;
   logic        hdr_fire;
   logic [5:0]  dt_w;
   logic [15:0] wc_w;

   function automatic logic is_long_dt(input logic [3:0] dt_lo);
      return (dt_lo == 4'h9) || (dt_lo == 4'hC) || (dt_lo == 4'hD) || (dt_lo == 4'hE);
   endfunction

   assign lane_d[0] = i_hs_d0;
   assign lane_d[1] = i_hs_d1;
   assign lane_d[2] = i_hs_d2;
   assign lane_d[3] = i_hs_d3;

   // start_blk stops a burst that straddles reset release from looking like a fresh rising edge
   assign oe0         = i_hs_oe[0];
   assign burst_start = oe0 & ~prev_oe & ~start_blk;

   always_comb begin
      sync_ok = 1'b1;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (!i_hs_oe[i] || (lane_d[i] != SYNC_BYTE)) sync_ok = 1'b0;
      end
   end

   // Header view: bytes of the current header cycle come from the lanes, earlier ones from hdr_q
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         if ((i / NUM_LANES) == int'(hdr_cyc)) hdr_w[i] = lane_d[i % NUM_LANES];
         else                                  hdr_w[i] = hdr_q[i];
      end
   end

   assign dt_w     = hdr_w[0][5:0];
   assign wc_w     = {hdr_w[2], hdr_w[1]};
   assign hdr_fire = (state == HDR) && oe0 && (hdr_cyc == HDR_LAST);

   // Header capture and payload byte countdown
   always_ff @(posedge i_mipi_tx_pclk) begin
      if (state == HDR) begin
         hdr_q   <= hdr_w;
         rem_cnt <= {1'b0, wc_w} + 17'd2;
      end else if (state == PAYLOAD) begin
         rem_cnt <= rem_cnt - LANE_STEP;
      end
   end

   always_ff @(posedge i_mipi_tx_pclk) begin
      if (i_rst) begin
         state           <= IDLE;
         prev_oe         <= 1'b0;
         start_blk       <= 1'b1;
         hdr_cyc         <= 2'd0;
         o_pkt_valid     <= 1'b0;
         o_long_done     <= 1'b0;
         o_pkt_vc        <= 2'd0;
         o_pkt_dt        <= 6'd0;
         o_pkt_wc        <= 16'd0;
         o_burst_cnt     <= '0;
         o_frame_cnt     <= '0;
         o_line_cnt      <= '0;
         o_long_cnt      <= '0;
         o_sync_err_cnt  <= '0;
         o_trunc_err_cnt <= '0;
      end else begin
         prev_oe     <= oe0;
         o_pkt_valid <= 1'b0;
         o_long_done <= 1'b0;
         if (!oe0) start_blk <= 1'b0;

         case (state)
            IDLE, DRAIN: begin
               if ((state == DRAIN) && !oe0) state <= IDLE;
               if (burst_start) begin
                  o_burst_cnt <= o_burst_cnt + CNT_ONE;
                  hdr_cyc     <= 2'd0;
                  if (sync_ok) begin
                     state <= HDR;
                  end else begin
                     o_sync_err_cnt <= o_sync_err_cnt + CNT_ONE;
                     state          <= DRAIN;
                  end
               end
            end

            HDR: begin
               if (!oe0) begin
                  o_trunc_err_cnt <= o_trunc_err_cnt + CNT_ONE;
                  state           <= IDLE;
               end else if (hdr_cyc == HDR_LAST) begin
                  o_pkt_valid <= 1'b1;
                  o_pkt_vc    <= hdr_w[0][7:6];
                  o_pkt_dt    <= dt_w;
                  o_pkt_wc    <= wc_w;
                  if (dt_w == 6'h01) o_frame_cnt <= o_frame_cnt + CNT_ONE;
                  if (dt_w == 6'h21) o_line_cnt  <= o_line_cnt + CNT_ONE;
                  state <= is_long_dt(dt_w[3:0]) ? PAYLOAD : DRAIN;
               end else begin
                  hdr_cyc <= hdr_cyc + 2'd1;
               end
            end

            PAYLOAD: begin
               if (!oe0) begin
                  o_trunc_err_cnt <= o_trunc_err_cnt + CNT_ONE;
                  state           <= IDLE;
               end else if (rem_cnt <= LANE_STEP) begin
                  o_long_done <= 1'b1;
                  o_long_cnt  <= o_long_cnt + CNT_ONE;
                  state       <= DRAIN;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

`ifdef DSI_HS_RX_MONITOR_ECC_CHECK_EN
   // 6-bit Hamming ECC over the 24 header bits, D0 = DI[0]
   function automatic logic [5:0] hdr_ecc(input logic [23:0] d);
      logic [5:0] p;
      p[0] = ^(d & 24'hF12CB7);
      p[1] = ^(d & 24'hF2555B);
      p[2] = ^(d & 24'h749A6D);
      p[3] = ^(d & 24'hB8E38E);
      p[4] = ^(d & 24'hDF03F0);
      p[5] = ^(d & 24'hEFFC00);
      return p;
   endfunction

   logic ecc_bad;
   assign ecc_bad = (hdr_ecc({hdr_w[2], hdr_w[1], hdr_w[0]}) != hdr_w[3][5:0]) ||
                    (hdr_w[3][7:6] != 2'b00);

   always_ff @(posedge i_mipi_tx_pclk) begin
      if (i_rst)                    o_ecc_err_cnt <= '0;
      else if (hdr_fire && ecc_bad) o_ecc_err_cnt <= o_ecc_err_cnt + CNT_ONE;
   end
`else
   assign o_ecc_err_cnt = '0;
`endif

endmodule

// File: tb/tb_dsi_hs_rx_monitor.sv
// Directed bench for dsi_hs_rx_monitor: a 4-lane instance and a 2-lane, 3-bit-counter instance.
module tb_dsi_hs_rx_monitor;

`ifdef DSI_HS_RX_MONITOR_ECC_CHECK_EN
   localparam int ECC_BAD_EXP = 1;
`else
   localparam int ECC_BAD_EXP = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [3:0]  oe_a = 4'h0;
   logic [7:0]  da0 = 8'h00, da1 = 8'h00, da2 = 8'h00, da3 = 8'h00;
   logic        pv_a, ld_a;
   logic [1:0]  vc_a;
   logic [5:0]  dt_a;
   logic [15:0] wc_a;
   logic [15:0] burst_a, frame_a, line_a, long_a, sync_a, trunc_a, ecc_a;

   logic [3:0]  oe_b = 4'h0;
   logic [7:0]  db0 = 8'h00, db1 = 8'h00;
   logic        pv_b, ld_b;
   logic [1:0]  vc_b;
   logic [5:0]  dt_b;
   logic [15:0] wc_b;
   logic [2:0]  burst_b, frame_b, line_b, long_b, sync_b, trunc_b, ecc_b;

   int vecs = 0;
   int errs = 0;
   int cyc  = 0;
   int pv_n_a = 0, pv_t_a = 0, ld_n_a = 0, ld_t_a = 0;
   int pv_n_b = 0, pv_t_b = 0, ld_n_b = 0, ld_t_b = 0;
   int t0;

   always #5 clk = ~clk;

   dsi_hs_rx_monitor #(.NUM_LANES(4), .CNT_W(16)) dut_a (
      .i_mipi_tx_pclk(clk), .i_rst(rst), .i_hs_oe(oe_a),
      .i_hs_d0(da0), .i_hs_d1(da1), .i_hs_d2(da2), .i_hs_d3(da3),
      .o_pkt_valid(pv_a), .o_pkt_vc(vc_a), .o_pkt_dt(dt_a), .o_pkt_wc(wc_a),
      .o_long_done(ld_a), .o_burst_cnt(burst_a), .o_frame_cnt(frame_a),
      .o_line_cnt(line_a), .o_long_cnt(long_a), .o_sync_err_cnt(sync_a),
      .o_trunc_err_cnt(trunc_a), .o_ecc_err_cnt(ecc_a)
   );

   dsi_hs_rx_monitor #(.NUM_LANES(2), .CNT_W(3)) dut_b (
      .i_mipi_tx_pclk(clk), .i_rst(rst), .i_hs_oe(oe_b),
      .i_hs_d0(db0), .i_hs_d1(db1), .i_hs_d2(8'h00), .i_hs_d3(8'h00),
      .o_pkt_valid(pv_b), .o_pkt_vc(vc_b), .o_pkt_dt(dt_b), .o_pkt_wc(wc_b),
      .o_long_done(ld_b), .o_burst_cnt(burst_b), .o_frame_cnt(frame_b),
      .o_line_cnt(line_b), .o_long_cnt(long_b), .o_sync_err_cnt(sync_b),
      .o_trunc_err_cnt(trunc_b), .o_ecc_err_cnt(ecc_b)
   );

   // Cycle index of the interval in which each pulse is seen
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (pv_a) begin pv_n_a++; pv_t_a = cyc + 1; end
      if (ld_a) begin ld_n_a++; ld_t_a = cyc + 1; end
      if (pv_b) begin pv_n_b++; pv_t_b = cyc + 1; end
      if (ld_b) begin ld_n_b++; ld_t_b = cyc + 1; end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc_a(input logic [3:0] oe, input logic [7:0] b0, b1, b2, b3);
      oe_a = oe; da0 = b0; da1 = b1; da2 = b2; da3 = b3;
      @(posedge clk);
      #1;
   endtask

   task automatic cyc_b(input logic [1:0] oe, input logic [7:0] b0, b1);
      oe_b = {2'b00, oe}; db0 = b0; db1 = b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      repeat (3) cyc_a(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
      check("rst_pv", 32'(pv_a), 0);
      check("rst_ld", 32'(ld_a), 0);
      check("rst_vc_dt_wc", {8'h00, vc_a, dt_a, wc_a}, 0);
      check("rst_burst", 32'(burst_a), 0);
      check("rst_frame", 32'(frame_a), 0);
      check("rst_sync", 32'(sync_a), 0);
      check("rst_trunc", 32'(trunc_a), 0);
      check("rst_burst_b", 32'(burst_b), 0);
      rst = 1'b0;
      repeat (2) cyc_a(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);

      // VSS short packet
      cyc_a(4'hF, 8'hB8, 8'hB8, 8'hB8, 8'hB8);
      t0 = cyc;
      cyc_a(4'hF, 8'h01, 8'h00, 8'h00, 8'h07);
      check("vss_pv", 32'(pv_a), 1);
      check("vss_dt", 32'(dt_a), 'h01);
      check("vss_vc_wc", {14'h0, vc_a, wc_a}, 0);
      check("vss_frame", 32'(frame_a), 1);
      check("vss_burst", 32'(burst_a), 1);
      cyc_a(4'hF, 8'h01, 8'h00, 8'h00, 8'h07);
      check("vss_pulse_width", 32'(pv_a), 0);
      cyc_a(4'hF, 8'hB8, 8'hB8, 8'hB8, 8'hB8);
      cyc_a(4'hF, 8'h01, 8'h00, 8'h00, 8'h07);
      check("drain_no_pkt", pv_n_a, 1);
      check("drain_frame", 32'(frame_a), 1);
      check("vss_latency", pv_t_a - t0, 2);
      cyc_a(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);

      // Long packet DT=0x3E WC=3240, started right as DRAIN exits
      cyc_a(4'hF, 8'hB8, 8'hB8, 8'hB8, 8'hB8);
      cyc_a(4'hF, 8'h3E, 8'hA8, 8'h0C, 8'h22);
      check("long_pv", 32'(pv_a), 1);
      check("long_dt", 32'(dt_a), 'h3E);
      check("long_wc", 32'(wc_a), 3240);
      for (int k = 0; k < 811; k++) cyc_a(4'hF, 8'(k), 8'(k + 1), 8'(k + 2), 8'(k + 3));
      check("long_done", 32'(ld_a), 1);
      check("long_cnt", 32'(long_a), 1);
      cyc_a(4'hF, 8'h00, 8'h00, 8'h00, 8'h00);
      check("long_done_width", 32'(ld_a), 0);
      check("long_done_n", ld_n_a, 1);
      check("long_latency", ld_t_a - pv_t_a, 811);
      check("long_burst", 32'(burst_a), 2);
      cyc_a(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);

      // Sync errors: bad byte on lane 2, then lane 3 not enabled
      cyc_a(4'hF, 8'hB8, 8'hB8, 8'hB9, 8'hB8);
      check("sync_burst", 32'(burst_a), 3);
      check("sync_err", 32'(sync_a), 1);
      cyc_a(4'hF, 8'h01, 8'h00, 8'h00, 8'h07);
      cyc_a(4'hF, 8'h01, 8'h00, 8'h00, 8'h07);
      check("sync_no_pkt", pv_n_a, 2);
      check("sync_frame", 32'(frame_a), 1);
      cyc_a(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
      cyc_a(4'h7, 8'hB8, 8'hB8, 8'hB8, 8'hB8);
      check("sync_oe_err", 32'(sync_a), 2);
      check("sync_oe_burst", 32'(burst_a), 4);
      cyc_a(4'hF, 8'h01, 8'h00, 8'h00, 8'h07);
      cyc_a(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);

      // Truncated WC=1000 payload, then HSS to show the monitor is back in IDLE
      cyc_a(4'hF, 8'hB8, 8'hB8, 8'hB8, 8'hB8);
      cyc_a(4'hF, 8'h3E, 8'hE8, 8'h03, 8'h07);
      check("trunc_wc", 32'(wc_a), 1000);
      repeat (10) cyc_a(4'hF, 8'h55, 8'h55, 8'h55, 8'h55);
      cyc_a(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
      check("trunc_err", 32'(trunc_a), 1);
      check("trunc_long", 32'(long_a), 1);
      check("trunc_ld_n", ld_n_a, 1);
      cyc_a(4'hF, 8'hB8, 8'hB8, 8'hB8, 8'hB8);
      cyc_a(4'hF, 8'h21, 8'h00, 8'h00, 8'h12);
      check("hss_pv", 32'(pv_a), 1);
      check("hss_dt", 32'(dt_a), 'h21);
      check("hss_line", 32'(line_a), 1);
      check("hss_burst", 32'(burst_a), 6);
      cyc_a(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
      cyc_a(4'hF, 8'hB8, 8'hB8, 8'hB8, 8'hB8);
      cyc_a(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
      check("hdr_trunc_pv", 32'(pv_a), 0);
      check("hdr_trunc_err", 32'(trunc_a), 2);
      check("hdr_trunc_burst", 32'(burst_a), 7);

      // Long packet with WC=0: CRC only
      cyc_a(4'hF, 8'hB8, 8'hB8, 8'hB8, 8'hB8);
      cyc_a(4'hF, 8'h29, 8'h00, 8'h00, 8'h1C);
      check("wc0_pv", 32'(pv_a), 1);
      cyc_a(4'hF, 8'hAA, 8'hBB, 8'h00, 8'h00);
      check("wc0_done", 32'(ld_a), 1);
      check("wc0_long", 32'(long_a), 2);
      cyc_a(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
      check("wc0_latency", ld_t_a - pv_t_a, 1);
      check("a_ecc_clean", 32'(ecc_a), 0);

      // 2-lane instance: corrupted ECC byte
      cyc_b(2'h3, 8'hB8, 8'hB8);
      t0 = cyc;
      cyc_b(2'h3, 8'h01, 8'h00);
      cyc_b(2'h3, 8'h00, 8'h06);
      check("b_pv", 32'(pv_b), 1);
      check("b_dt", 32'(dt_b), 'h01);
      check("b_frame", 32'(frame_b), 1);
      cyc_b(2'h3, 8'h00, 8'h00);
      check("b_latency", pv_t_b - t0, 3);
      check("b_ecc_err", 32'(ecc_b), ECC_BAD_EXP);
      cyc_b(2'h0, 8'h00, 8'h00);
      cyc_b(2'h3, 8'hB8, 8'hB8);
      cyc_b(2'h3, 8'h01, 8'h00);
      cyc_b(2'h3, 8'h00, 8'h07);
      check("b_frame2", 32'(frame_b), 2);
      check("b_ecc_good", 32'(ecc_b), ECC_BAD_EXP);
      cyc_b(2'h0, 8'h00, 8'h00);
      cyc_b(2'h3, 8'hB8, 8'hB8);
      cyc_b(2'h3, 8'h29, 8'h03);
      cyc_b(2'h3, 8'h00, 8'h1A);
      check("b_long_wc", 32'(wc_b), 3);
      repeat (3) cyc_b(2'h3, 8'h11, 8'h22);
      check("b_long_done", 32'(ld_b), 1);
      check("b_long_cnt", 32'(long_b), 1);
      cyc_b(2'h0, 8'h00, 8'h00);
      check("b_long_latency", ld_t_b - pv_t_b, 3);
      repeat (6) begin
         cyc_b(2'h3, 8'hB8, 8'h00);
         cyc_b(2'h0, 8'h00, 8'h00);
      end
      check("b_burst_wrap", 32'(burst_b), 1);
      check("b_sync_err", 32'(sync_b), 6);

      // Reset pulsed mid-payload with OE held high
      cyc_a(4'hF, 8'hB8, 8'hB8, 8'hB8, 8'hB8);
      cyc_a(4'hF, 8'h3E, 8'hE8, 8'h03, 8'h07);
      repeat (5) cyc_a(4'hF, 8'h33, 8'h33, 8'h33, 8'h33);
      rst = 1'b1;
      repeat (2) cyc_a(4'hF, 8'hB8, 8'hB8, 8'hB8, 8'hB8);
      check("mid_rst_burst", 32'(burst_a), 0);
      check("mid_rst_counts", 32'(frame_a | line_a | long_a | sync_a | trunc_a), 0);
      check("mid_rst_hdr", {8'h00, vc_a, dt_a, wc_a}, 0);
      check("mid_rst_pv", 32'(pv_a), 0);
      rst = 1'b0;
      repeat (3) cyc_a(4'hF, 8'hB8, 8'hB8, 8'hB8, 8'hB8);
      check("post_rst_no_burst", 32'(burst_a), 0);
      check("post_rst_no_sync", 32'(sync_a), 0);
      cyc_a(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
      cyc_a(4'hF, 8'hB8, 8'hB8, 8'hB8, 8'hB8);
      cyc_a(4'hF, 8'h01, 8'h00, 8'h00, 8'h07);
      check("post_rst_burst", 32'(burst_a), 1);
      check("post_rst_frame", 32'(frame_a), 1);
      check("post_rst_pv", 32'(pv_a), 1);
      cyc_a(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
